// File: rtl/serial_tx_pkg.sv
// Shared line-level definitions for the serial link: frame state encodings,
// idle line level and a counter-width helper, reused by transmitter and receiver.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Counter width that never collapses to zero bits for a count of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period with bit_end.
module serial_bit_timer
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first,
// optional even parity, stop bit; each bit held CLKS_PER_BIT clocks.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int IW = cnt_w(DATA_W);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic [IW-1:0]     idx_q;
    logic              done_q;
    logic              bit_end;
    logic              accept;

    assign accept = (state_q == ST_IDLE) && din_valid;

    // The period counter sits at zero while idle so START gets a full period.
    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == ST_IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (din_valid) state_d = ST_START;
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end && (idx_q == LAST_BIT)) begin
                    state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Frame payload is captured once at acceptance; later din changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_q <= din;
            par_q   <= (PARITY_EN != 0) ? ^din : 1'b0;
        end else if ((state_q == ST_DATA) && bit_end) begin
            shift_q <= shift_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_STOP) && bit_end;
            if (state_q != ST_DATA) begin
                idx_q <= '0;
            end else if (bit_end && (idx_q != LAST_BIT)) begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

    always_comb begin
        txd = LINE_IDLE;
        case (state_q)
            ST_START:  txd = ~LINE_IDLE;
            ST_DATA:   txd = shift_q[0];
            ST_PARITY: txd = par_q;
            default:   txd = LINE_IDLE;
        endcase
    end

    assign din_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule
